// File: rtl/ram_pkg.sv
// Shared definitions for the ram_v2_sdp storage block.
//   state_e          : clear-sequencer states (StInit zeroes the array, StRun serves traffic)
//   RDW_OLD/RDW_NEW  : read-during-write selections for RDW_MODE
//   be_width()       : number of byte enables for a given word width
//   width_ok(),
//   latency_ok()     : elaboration-time legality checks used by the top level
package ram_pkg;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic bit width_ok(input int unsigned data_width);
        return (data_width != 0) && (data_width % 8 == 0);
    endfunction

    function automatic bit latency_ok(input int unsigned rd_latency);
        return (rd_latency >= 1) && (rd_latency <= 3);
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data delay line of Depth stages carrying {valid, data}.
//   clk_i, rst_ni      : clock, asynchronous active-low clear of all stages
//   valid_i, data_i    : stage input
//   valid_o, data_o    : stage output after Depth cycles (pass-through when Depth == 0)
// A stage only loads data when its incoming valid is set, so the output data holds
// the last delivered word while valid_o is low.
module ram_rd_pipe #(
    parameter int unsigned Depth = 0,
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    if (Depth == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign valid_o = valid_i;
        assign data_o  = data_i;
    end else begin : g_stages
        logic [Depth-1:0] vld_q;
        logic [Width-1:0] dat_q [Depth];

        // Index i of the chain is the input of stage i; index Depth is the output.
        logic [Depth:0]   vld_chain;
        logic [Width-1:0] dat_chain [Depth+1];

        assign vld_chain[0] = valid_i;
        assign dat_chain[0] = data_i;
        for (genvar g = 0; g < Depth; g++) begin : g_chain
            assign vld_chain[g+1] = vld_q[g];
            assign dat_chain[g+1] = dat_q[g];
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
                for (int i = 0; i < Depth; i++) begin
                    dat_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < Depth; i++) begin
                    vld_q[i] <= vld_chain[i];
                    if (vld_chain[i]) begin
                        dat_q[i] <= dat_chain[i];
                    end
                end
            end
        end

        assign valid_o = vld_chain[Depth];
        assign data_o  = dat_chain[Depth];
    end

endmodule

// File: rtl/ram_v2_sdp.sv
// Simple-dual-port synchronous RAM with byte enables, read pipeline and clear sequencer.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   wr_en_i/addr/data/be     : write port, byte-granular
//   rd_en_i/rd_addr_i        : read request, array sampled at the accepting edge
//   rd_data_o, rd_valid_o    : read result, RD_LATENCY cycles after acceptance
//   init_start_i             : request a full-array clear (ignored while clearing)
//   init_busy_o              : clear in progress; reads/writes are dropped meanwhile
//   collision_o              : same-address read and write accepted on the previous edge
module ram_v2_sdp
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned RDW_MODE       = 0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic                    rd_en_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    init_start_i,
    output logic                    init_busy_o,
    output logic                    collision_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned BeW   = be_width(DATA_WIDTH);

    if (!width_ok(DATA_WIDTH)) begin : g_bad_width
        $error("ram_v2_sdp: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (!latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("ram_v2_sdp: RD_LATENCY must be in 1..3");
    end

    // Clear sequencer
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLEAR_ON_RESET ? StInit : StRun;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (init_start_i) begin
                        state_q <= StInit;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    logic running;
    logic wr_acc;
    logic rd_acc;
    logic same_addr;

    assign running     = (state_q == StRun);
    assign init_busy_o = ~running;
    assign wr_acc      = running & wr_en_i;
    assign rd_acc      = running & rd_en_i;
    assign same_addr   = (wr_addr_i == rd_addr_i);

    // Storage; never reset, zeroed one word per cycle by the sequencer.
    logic [DATA_WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!running) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BeW; i++) begin
                if (wr_be_i[i]) begin
                    mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
                end
            end
        end
    end

    // Read sample, optionally forwarding the enabled write bytes on an address match.
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_merged;
    logic [DATA_WIDTH-1:0] rd_data_d;

    assign rd_word = mem_q[rd_addr_i];

    always_comb begin
        rd_merged = rd_word;
        for (int i = 0; i < BeW; i++) begin
            if (wr_be_i[i]) begin
                rd_merged[8*i +: 8] = wr_data_i[8*i +: 8];
            end
        end
    end

    assign rd_data_d = (RDW_MODE == RDW_NEW && wr_acc && same_addr) ? rd_merged : rd_word;

    // First read stage doubles as the output register when RD_LATENCY == 1.
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  collision_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            collision_q <= 1'b0;
        end else begin
            rd_valid_q  <= rd_acc;
            collision_q <= rd_acc & wr_acc & same_addr;
            if (rd_acc) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign collision_o = collision_q;

    ram_rd_pipe #(
        .Depth (RD_LATENCY - 1),
        .Width (DATA_WIDTH)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (rd_valid_q),
        .data_i  (rd_data_q),
        .valid_o (rd_valid_o),
        .data_o  (rd_data_o)
    );

endmodule

// File: doc/ram_v2_sdp.md
Name: ram_v2_sdp

Overview:
Parametrised simple-dual-port synchronous RAM; next generation of the single-port ram_v1 storage block.
- Separate write and read ports, both usable every cycle.
- Per-byte write enables, configurable read pipeline latency with a valid strobe, and selectable read-during-write semantics.
- Hardware clear sequencer zeroes the array after reset or on request; downstream logic keys off rd_valid and init_busy.

Parameters:
ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH words.
DATA_WIDTH, 32, word width; must be a multiple of 8 (elaboration-time error otherwise).
RD_LATENCY, 1, cycles from accepted rd_en to rd_valid; legal 1..3 (elaboration error otherwise).
RDW_MODE, 0, same-address read/write in one cycle: 0 = return old word, 1 = return byte-merged new word.
CLEAR_ON_RESET, 1, 1 = run clear sequence after reset release; 0 = array contents undefined after reset.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write request.
wr_addr  in  ADDR_WIDTH  write address.
wr_data  in  DATA_WIDTH  write data.
wr_be  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
rd_en  in  1  read request.
rd_addr  in  ADDR_WIDTH  read address.
rd_data  out  DATA_WIDTH  read data, meaningful when rd_valid=1.
rd_valid  out  1  read data strobe.
init_start  in  1  single-cycle pulse requesting an array clear.
init_busy  out  1  clear sequence in progress.
collision  out  1  same-address read/write accepted in the same cycle.

Behaviour:
- Reset (rst_n low, async):
  - rd_data=0, rd_valid=0, collision=0; read pipeline flushed.
  - FSM enters INIT if CLEAR_ON_RESET=1, else RUN; init_busy = CLEAR_ON_RESET while in reset.
  - The array itself is never reset.
- FSM states: INIT, RUN.
  - INIT: counter starts at 0; one word written to zero per cycle. Leaves INIT on the cycle after address DEPTH-1 is written, so init_busy is high for exactly DEPTH cycles after rst_n rises.
  - RUN: init_start=1 -> INIT, counter reset to 0. init_start is ignored while already in INIT.
  - Reset asserted mid-INIT aborts the sequence; it restarts from address 0 after release.
- During INIT:
  - wr_en and rd_en are ignored: writes are dropped, no rd_valid is generated.
  - Reads already in flight in the pipeline still complete.
- Write (RUN, wr_en=1): at the clock edge, only bytes with wr_be[i]=1 are updated. wr_be=0 is a no-op.
- Read (RUN, rd_en=1):
  - Array is sampled at the accepting edge.
  - rd_valid is high exactly RD_LATENCY cycles later, for one cycle per accepted read.
  - Back-to-back reads give back-to-back valids, in order.
  - rd_data holds its last value while rd_valid=0.
- Read-during-write to different addresses: independent; the read returns the pre-existing word.
- Read-during-write to the same address (rd_en, wr_en, addresses equal, RUN):
  - collision=1 for that one cycle, registered, aligned with the accepting edge +1.
  - RDW_MODE=0 returns the old word.
  - RDW_MODE=1 returns the old word with the wr_be bytes replaced by wr_data.
- A read in the cycle immediately after a write always sees the new data.
- Address wrap: none needed; addresses are full-width and cover DEPTH exactly.

Decomposition:
- Package ram_pkg holds:
  - state enum (INIT, RUN);
  - RDW_OLD/RDW_NEW constants;
  - function to compute byte-enable width;
  - shared elaboration-check macros.
- Sub-module ram_rd_pipe: parametrised shift register of depth RD_LATENCY-1 carrying {valid, data}, with async active-low clear.
- Array, byte-merge, RDW and FSM logic live in ram_v2_sdp.

Test Plan:
1. Release rst_n, defaults -> init_busy high exactly 1024 cycles. Then read 0x3FF -> rd_valid one cycle later, rd_data=0x00000000.
2. Write 0xDEADBEEF @0x010, be=4'hF; read 0x010 the next cycle -> rd_data=0xDEADBEEF, rd_valid after RD_LATENCY.
3. Write 0xFFFFEEEE @0x010, be=4'h3 -> readback 0xDEADEEEE. Then write with be=4'h0 -> still 0xDEADEEEE.
4. Same-cycle write 0x12345678 be=4'hC plus read @0x010 -> collision=1. RDW_MODE=0 returns 0xDEADEEEE; RDW_MODE=1 returns 0x1234EEEE. A following read returns 0x1234EEEE.
5. Drop rst_n at init count 500 -> rd_data=0, rd_valid=0 immediately. After release, init_busy high 1024 more cycles. A write issued during INIT is absent afterwards (reads 0).
6. RD_LATENCY=3: preload 0x0..0x3 with 0xA0..0xA3, issue 4 consecutive reads. Pulse init_start on the cycle after the last read -> rd_valid high 4 consecutive cycles starting 3 cycles after the first read, data 0xA0..0xA3 in order. All in-flight reads complete despite INIT.
